mac_term_sequencer: RTL and testbench
=====================================

// Module: mac_term_sequencer
// PURPOSE
//  Sequences the constant/function/accumulator mux datapath for one evaluation per input sample.
//  On a sample strobe it walks N_TERMS product terms. For each term it:
//   - selects the coefficient,
//   - waits out the multiplier pipeline,
//   - commands the accumulator (load on the first term, add on the rest).
//  When all terms are done it pulses the output-register load.
//  Sits between the sample-ready flag and the sel_const/sel_fun/sel_acum mux selects.
// PARAMETERS
//  N_TERMS  5  product terms per evaluation, legal 1..8 (sel_const indexes 0..N_TERMS-1)
//  MUL_LAT  2  multiplier pipeline latency in cycles, legal 1..7
//  N_FUN    3  number of valid function codes; codes >= N_FUN are clamped to 0
// PORTS
//  clk         in   1  clock, rising edge
//  rst         in   1  reset, asynchronous, active-high
//  sample_stb  in   1  new-sample flag, single-cycle pulse
//  fun_sel_in  in   2  function code; captured only when sample_stb is accepted
//  ovr_clr     in   1  clears overrun
//  sel_const   out  3  coefficient mux select = current term index
//  sel_fun     out  2  function mux select, held between evaluations
//  sel_acum    out  1  0 = accumulator loads product, 1 = accumulator adds product
//  acc_en      out  1  accumulator write enable, 1-cycle pulse per term
//  out_load    out  1  result-register load, 1-cycle pulse
//  done        out  1  evaluation complete, 1-cycle pulse, coincident with out_load
//  busy        out  1  high in any state other than IDLE
//  overrun     out  1  sticky: a strobe arrived while an evaluation was running
// BEHAVIOUR
//  - rst: state IDLE, term counter k=0, wait counter 0.
//    All outputs 0, including sel_fun and overrun.
//    Asserting rst mid-evaluation aborts it: no done and no out_load are produced.
//  - All outputs are registered (Moore), decoded from state and k.
//  - FSM states IDLE, ISSUE, WAIT, ACCUM, FINISH:
//    IDLE   - busy=0, sel_const=0.
//             sample_stb=1: capture sel_fun (clamped), set k=0, go to ISSUE.
//    ISSUE  - 1 cycle, sel_const=k. Load wait counter with MUL_LAT, go to WAIT.
//    WAIT   - MUL_LAT cycles, sel_const held at k, then go to ACCUM.
//    ACCUM  - 1 cycle: acc_en=1, sel_acum=(k!=0), sel_const=k.
//             If k==N_TERMS-1 go to FINISH, else k<=k+1 and go to ISSUE.
//    FINISH - 1 cycle: done=1, out_load=1, busy=1.
//             sample_stb=1 here: accepted, go straight to ISSUE (back-to-back) with k=0.
//             Otherwise go to IDLE.
//  - Timing, with cycle c being the cycle after the edge that sampled the strobe (c=0):
//    - term k occupies cycles k*(MUL_LAT+2) .. (k+1)*(MUL_LAT+2)-1;
//    - acc_en is high in the last cycle of each term;
//    - done is high in cycle N_TERMS*(MUL_LAT+2).
//  - sel_acum is 0 outside ACCUM. k never wraps past N_TERMS-1.
//  - sample_stb in ISSUE, WAIT or ACCUM: ignored, the sequence is unaffected, overrun<=1.
//  - overrun: ovr_clr=1 clears it next cycle; if a set and ovr_clr occur in the same cycle, set wins.
// TESTING
//  - Defaults, strobe with fun_sel_in=2:
//    -> sel_fun=2 from c0; sel_const 0,1,2,3,4 each held 4 cycles;
//    -> acc_en at c3,7,11,15,19; sel_acum=0 at c3, 1 at the others;
//    -> done and out_load at c20; busy c0..c20; IDLE at c21.
//  - Strobe again in the c20 FINISH cycle
//    -> done=1 at c20, c21 is ISSUE with sel_const=0, overrun stays 0.
//  - Strobe at c5
//    -> ignored, overrun=1 from c6, done still at c20.
//    -> ovr_clr pulse then clears it; ovr_clr coincident with a new overrun strobe leaves overrun=1.
//  - rst pulse at c9
//    -> all outputs 0 asynchronously, no done.
//    -> a later strobe runs a full 21-cycle sequence.
//  - N_TERMS=1, MUL_LAT=1
//    -> ISSUE c0, WAIT c1, acc_en with sel_acum=0 at c2, done at c3.
//  - fun_sel_in=3 with N_FUN=3
//    -> sel_fun=0; the sequence otherwise normal.

Source files
------------

// File: rtl/mac_term_sequencer.sv
// mac_term_sequencer
// Drives the coefficient, function and accumulator mux selects of a shared
// multiply-accumulate datapath. Each accepted sample strobe starts one
// evaluation. An evaluation walks N_TERMS product terms, and each term takes
// ISSUE, then MUL_LAT WAIT cycles, then ACCUM. After the last term, the FINISH
// cycle pulses the result-register load. Every output is a flop that is loaded
// from the next-state decode, so a cycle's outputs always match that cycle's
// state.

module mac_term_sequencer #(
    parameter int N_TERMS = 5,  // 1..8
    parameter int MUL_LAT = 2,  // 1..7
    parameter int N_FUN   = 3   // codes >= N_FUN clamp to 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sample_stb_i,
    input  logic [1:0] fun_sel_i,
    input  logic       ovr_clr_i,
    output logic [2:0] sel_const_o,
    output logic [1:0] sel_fun_o,
    output logic       sel_acum_o,
    output logic       acc_en_o,
    output logic       out_load_o,
    output logic       done_o,
    output logic       busy_o,
    output logic       overrun_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_ACCUM,
        S_FINISH
    } state_t;

    localparam logic [2:0] LAST_K = 3'(N_TERMS - 1);
    localparam logic [2:0] LAT    = 3'(MUL_LAT);

    state_t     state_q, state_d;
    logic [2:0] k_q, k_d;
    logic [2:0] wcnt_q, wcnt_d;
    logic [1:0] sel_fun_q, sel_fun_d;
    logic       overrun_q, overrun_d;
    logic       accept;
    logic       ovr_set;

    logic [2:0] sel_const_q, sel_const_d;
    logic       sel_acum_q, sel_acum_d;
    logic       acc_en_q, acc_en_d;
    logic       finish_q, finish_d;
    logic       busy_q, busy_d;

    // Next-state logic: term walk, multiplier wait count, strobe acceptance and overrun.
    always_comb begin
        // NOTE: every signal gets a default before the case; otherwise a path
        // that leaves a signal unassigned would infer a latch.
        state_d   = state_q;
        k_d       = k_q;
        wcnt_d    = wcnt_q;
        sel_fun_d = sel_fun_q;
        accept    = 1'b0;
        ovr_set   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (sample_stb_i) accept = 1'b1;
            end
            S_ISSUE: begin
                wcnt_d  = LAT;
                state_d = S_WAIT;
                ovr_set = sample_stb_i;
            end
            S_WAIT: begin
                if (wcnt_q <= 3'd1) state_d = S_ACCUM;
                else                wcnt_d  = wcnt_q - 3'd1;
                ovr_set = sample_stb_i;
            end
            S_ACCUM: begin
                if (k_q == LAST_K) begin
                    state_d = S_FINISH;
                end else begin
                    k_d     = k_q + 3'd1;
                    state_d = S_ISSUE;
                end
                ovr_set = sample_stb_i;
            end
            S_FINISH: begin
                // A strobe in the final cycle starts the next evaluation back-to-back.
                if (sample_stb_i) accept  = 1'b1;
                else              state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (accept) begin
            state_d   = S_ISSUE;
            k_d       = 3'd0;
            sel_fun_d = (int'(fun_sel_i) >= N_FUN) ? 2'd0 : fun_sel_i;
        end

        // A new overrun in the same cycle as a clear takes priority.
        if (ovr_set)        overrun_d = 1'b1;
        else if (ovr_clr_i) overrun_d = 1'b0;
        else                overrun_d = overrun_q;
    end

    // Output decode from the next state, so the output flops line up with the state flops.
    always_comb begin
        sel_const_d = (state_d == S_IDLE) ? 3'd0 : k_d;
        acc_en_d    = (state_d == S_ACCUM);
        sel_acum_d  = (state_d == S_ACCUM) && (k_d != 3'd0);
        finish_d    = (state_d == S_FINISH);
        busy_d      = (state_d != S_IDLE);
    end

    // State, counters and output flops; an asynchronous reset aborts any evaluation.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state flops use non-blocking assignments so that every register
        // samples the values from before this edge, whatever the statement order.
        if (rst) begin
            state_q     <= S_IDLE;
            k_q         <= 3'd0;
            wcnt_q      <= 3'd0;
            sel_fun_q   <= 2'd0;
            overrun_q   <= 1'b0;
            sel_const_q <= 3'd0;
            sel_acum_q  <= 1'b0;
            acc_en_q    <= 1'b0;
            finish_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            wcnt_q      <= wcnt_d;
            sel_fun_q   <= sel_fun_d;
            overrun_q   <= overrun_d;
            sel_const_q <= sel_const_d;
            sel_acum_q  <= sel_acum_d;
            acc_en_q    <= acc_en_d;
            finish_q    <= finish_d;
            busy_q      <= busy_d;
        end
    end

    assign sel_const_o = sel_const_q;
    assign sel_fun_o   = sel_fun_q;
    assign sel_acum_o  = sel_acum_q;
    assign acc_en_o    = acc_en_q;
    assign out_load_o  = finish_q;
    assign done_o      = finish_q;
    assign busy_o      = busy_q;
    assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_mac_term_sequencer.sv
// tb_mac_term_sequencer
// Runs two sequencers from one shared stimulus stream. The first uses the
// default parameters. The second has N_TERMS=1 and MUL_LAT=1. For each
// instance, a reference model keeps a cycle count from the start of the
// current evaluation. The model works out the expected outputs from the timing
// rules: term k covers cycles k*(MUL_LAT+2) onward, acc_en is high in the last
// cycle of each term, and done comes at N_TERMS*(MUL_LAT+2).

module tb_mac_term_sequencer;

    typedef struct packed {
        logic [2:0] sel_const;
        logic [1:0] sel_fun;
        logic       sel_acum;
        logic       acc_en;
        logic       out_load;
        logic       done;
        logic       busy;
        logic       overrun;
    } obs_t;

    localparam int NT [2] = '{5, 1};
    localparam int ML [2] = '{2, 1};
    localparam int NF     = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       stb;
    logic [1:0] fun;
    logic       clr;

    logic [2:0] a_sel_const, b_sel_const;
    logic [1:0] a_sel_fun,   b_sel_fun;
    logic       a_sel_acum, a_acc_en, a_out_load, a_done, a_busy, a_overrun;
    logic       b_sel_acum, b_acc_en, b_out_load, b_done, b_busy, b_overrun;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state for each instance.
    bit       m_active [2];
    int       m_c      [2];
    bit [1:0] m_fun    [2];
    bit       m_ovr    [2];

    always #5 clk = ~clk;

    mac_term_sequencer #(.N_TERMS(5), .MUL_LAT(2), .N_FUN(3)) dut_a (
        .clk(clk), .rst(rst), .sample_stb_i(stb), .fun_sel_i(fun), .ovr_clr_i(clr),
        .sel_const_o(a_sel_const), .sel_fun_o(a_sel_fun), .sel_acum_o(a_sel_acum),
        .acc_en_o(a_acc_en), .out_load_o(a_out_load), .done_o(a_done),
        .busy_o(a_busy), .overrun_o(a_overrun)
    );

    mac_term_sequencer #(.N_TERMS(1), .MUL_LAT(1), .N_FUN(3)) dut_b (
        .clk(clk), .rst(rst), .sample_stb_i(stb), .fun_sel_i(fun), .ovr_clr_i(clr),
        .sel_const_o(b_sel_const), .sel_fun_o(b_sel_fun), .sel_acum_o(b_sel_acum),
        .acc_en_o(b_acc_en), .out_load_o(b_out_load), .done_o(b_done),
        .busy_o(b_busy), .overrun_o(b_overrun)
    );

    task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s @%0t: observed %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    function automatic obs_t expect_of(input int i);
        obs_t e;
        int   per;
        e         = '0;
        e.sel_fun = m_fun[i];
        e.overrun = m_ovr[i];
        if (m_active[i]) begin
            per    = ML[i] + 2;
            e.busy = 1'b1;
            if (m_c[i] == NT[i] * per) begin
                e.done      = 1'b1;
                e.out_load  = 1'b1;
                e.sel_const = 3'(NT[i] - 1);
            end else begin
                e.sel_const = 3'(m_c[i] / per);
                e.acc_en    = (m_c[i] % per) == per - 1;
                e.sel_acum  = e.acc_en && (m_c[i] / per != 0);
            end
        end
        return e;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_active[i] = 1'b0;
            m_c[i]      = 0;
            m_fun[i]    = 2'd0;
            m_ovr[i]    = 1'b0;
        end
    endtask

    // Advance each model by one clock edge with the given inputs.
    task automatic model_step(input logic s, input logic [1:0] f, input logic c);
        bit finishing;
        for (int i = 0; i < 2; i++) begin
            finishing = m_active[i] && (m_c[i] == NT[i] * (ML[i] + 2));
            if (s && m_active[i] && !finishing) m_ovr[i] = 1'b1;
            else if (c)                         m_ovr[i] = 1'b0;
            if (s && (!m_active[i] || finishing)) begin
                m_active[i] = 1'b1;
                m_c[i]      = 0;
                m_fun[i]    = (int'(f) >= NF) ? 2'd0 : f;
            end else if (m_active[i]) begin
                if (finishing) m_active[i] = 1'b0;
                else           m_c[i]++;
            end
        end
    endtask

    task automatic check_all();
        obs_t o [2];
        obs_t e;
        string nm;
        o[0] = {a_sel_const, a_sel_fun, a_sel_acum, a_acc_en, a_out_load, a_done, a_busy, a_overrun};
        o[1] = {b_sel_const, b_sel_fun, b_sel_acum, b_acc_en, b_out_load, b_done, b_busy, b_overrun};
        for (int i = 0; i < 2; i++) begin
            e  = expect_of(i);
            nm = (i == 0) ? "a" : "b";
            check({nm, ".sel_const"}, o[i].sel_const,     e.sel_const);
            check({nm, ".sel_fun"},   3'(o[i].sel_fun),   3'(e.sel_fun));
            check({nm, ".sel_acum"},  3'(o[i].sel_acum),  3'(e.sel_acum));
            check({nm, ".acc_en"},    3'(o[i].acc_en),    3'(e.acc_en));
            check({nm, ".out_load"},  3'(o[i].out_load),  3'(e.out_load));
            check({nm, ".done"},      3'(o[i].done),      3'(e.done));
            check({nm, ".busy"},      3'(o[i].busy),      3'(e.busy));
            check({nm, ".overrun"},   3'(o[i].overrun),   3'(e.overrun));
        end
    endtask

    // Drive inputs for one cycle, advance the model, then check just after the edge.
    task automatic cycle(input logic s, input logic [1:0] f, input logic c);
        stb = s;
        fun = f;
        clr = c;
        model_step(s, f, c);
        @(posedge clk);
        #1;
        check_all();
    endtask

    // Assert reset away from the clock edge, confirm the outputs clear at once, then release.
    task automatic do_reset();
        stb = 1'b0;
        clr = 1'b0;
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        stb = 1'b0;
        fun = 2'd0;
        clr = 1'b0;
        model_reset();
        #12;
        check_all();
        @(negedge clk);
        rst = 1'b0;

        // Basic evaluation with function code 2, then one idle cycle.
        cycle(1'b1, 2'd2, 1'b0);
        repeat (21) cycle(1'b0, 2'd0, 1'b0);

        // Back-to-back: strobe again in the FINISH cycle.
        cycle(1'b1, 2'd2, 1'b0);
        repeat (20) cycle(1'b0, 2'd0, 1'b0);
        cycle(1'b1, 2'd1, 1'b0);

        // Strobe at c5 is ignored and sets overrun; the clear comes after done.
        repeat (5) cycle(1'b0, 2'd0, 1'b0);
        cycle(1'b1, 2'd0, 1'b0);
        repeat (14) cycle(1'b0, 2'd0, 1'b0);
        cycle(1'b0, 2'd0, 1'b1);
        cycle(1'b0, 2'd0, 1'b0);

        // A set and a clear in the same cycle leave overrun high.
        cycle(1'b1, 2'd1, 1'b0);
        cycle(1'b1, 2'd2, 1'b1);
        repeat (21) cycle(1'b0, 2'd0, 1'b0);
        cycle(1'b0, 2'd0, 1'b1);

        // Function code 3 clamps to 0.
        cycle(1'b1, 2'd3, 1'b0);
        repeat (21) cycle(1'b0, 2'd0, 1'b0);

        // Reset at c9 aborts the evaluation; a later strobe runs the full sequence.
        cycle(1'b1, 2'd2, 1'b0);
        repeat (9) cycle(1'b0, 2'd0, 1'b0);
        do_reset();
        repeat (3) cycle(1'b0, 2'd0, 1'b0);
        cycle(1'b1, 2'd1, 1'b0);
        repeat (22) cycle(1'b0, 2'd0, 1'b0);

        // Random traffic: strobes, clears, function codes and an occasional reset.
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 199) == 0) do_reset();
            cycle(($urandom_range(0, 5) == 0), 2'($urandom_range(0, 3)),
                  ($urandom_range(0, 7) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
